fifo_feed_ctrl: RTL

Sequencer for a bank of `LANES` delay fifos (shift-register buffers, `DEPTH` entries of `BITS` each) that feed a systolic MAC array. It has two phases:
- **Fill:** accepts operand beats from the host/MMIO side and steers each beat into its target lane's fifo.
- **Drain:** shifts all lanes out with a one-cycle-per-lane skew while enabling the array.

It sits between the CCI-P MMIO write decode and the fifo/MAC datapath, and owns every fifo `en`/`d` pin.

---
 rtl/fifo_feed_pkg.sv | 27 ++
 rtl/fifo_feed_skew.sv | 21 ++
 rtl/fifo_feed_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_feed_pkg.sv
// Shared types and width helpers for the fifo feed sequencer.
package fifo_feed_pkg;

  // Pass phases of the sequencer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  // Width of a lane index; kept at least 1 bit so a single-lane build still has a port.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Width of a per-lane fill counter that must be able to hold DEPTH itself.
  function automatic int lane_cnt_w(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  // Width of the drain step counter t (0 .. DEPTH+LANES-2).
  function automatic int drain_cnt_w(input int depth, input int lanes);
    return ((depth + lanes) > 1) ? $clog2(depth + lanes) : 1;
  endfunction

endpackage

// File: rtl/fifo_feed_skew.sv
// Skewed drain enable: lane i shifts for DEPTH consecutive steps starting at step i.
module fifo_feed_skew
  import fifo_feed_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 8,
  parameter int TW    = drain_cnt_w(DEPTH, LANES)
) (
  input  logic [TW-1:0]    t,
  output logic [LANES-1:0] mask
);

  // One window comparison per lane.
  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[i] = (int'(t) >= i) && (int'(t) < (i + DEPTH));
    end
  end

endmodule

// File: rtl/fifo_feed_ctrl.sv
// Fill/drain sequencer for a bank of delay fifos feeding a systolic MAC array.
// Optional build macro: FIFO_FEED_PERF_EN adds the perf_cycles pass-length counter.
//
// Load handshake: a beat transfers on a cycle where load_valid and load_ready are
// both high. load_ready is independent of load_valid, is only ever high in FILL,
// and stays low for a lane that already holds DEPTH entries, so such a beat waits
// rather than being dropped. Beats addressed past the last lane are accepted and
// discarded so the host side can never hang on a bad index.
module fifo_feed_ctrl
  import fifo_feed_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          load_valid,
  input  logic [lane_idx_w(LANES)-1:0]  load_lane,
  input  logic [BITS-1:0]               load_data,
  output logic                          load_ready,
  output logic [LANES-1:0]              fifo_en,
  output logic [LANES*BITS-1:0]         fifo_d,
  output logic                          array_en,
  output logic                          busy,
  output logic                          done
`ifdef FIFO_FEED_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int CW = lane_cnt_w(DEPTH);
  localparam int TW = drain_cnt_w(DEPTH, LANES);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(DEPTH + LANES - 2);

  feed_state_t      state;
  logic [CW-1:0]    lane_cnt [LANES];
  logic [TW-1:0]    t;

  logic             lane_ok;
  logic [LANES-1:0] sel;
  logic [LANES-1:0] full;
  logic [LANES-1:0] full_next;
  logic [LANES-1:0] fill_en;
  logic [LANES-1:0] skew_mask;
  logic             ready_c;
  logic             accept;

  fifo_feed_skew #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_skew (
    .t    (t),
    .mask (skew_mask)
  );

  // Lane decode, fullness and the FILL-phase accept decision.
  always_comb begin
    lane_ok   = int'(load_lane) < LANES;
    sel       = '0;
    full      = '0;
    full_next = '0;
    for (int i = 0; i < LANES; i++) begin
      sel[i]  = lane_ok && (int'(load_lane) == i);
      full[i] = (lane_cnt[i] == CNT_FULL);
    end
    ready_c = (state == FILL) && ((sel & full) == '0);
    accept  = load_valid && ready_c;
    fill_en = accept ? sel : '0;
    // Fullness after this edge, so DRAIN starts right after the last beat.
    for (int i = 0; i < LANES; i++) begin
      full_next[i] = full[i] || (fill_en[i] && (lane_cnt[i] == CNT_LAST));
    end
  end

  // Output decode: FILL follows the load inputs, DRAIN/DONE follow only state and t.
  always_comb begin
    load_ready = ready_c;
    fifo_en    = '0;
    fifo_d     = '0;
    array_en   = (state == DRAIN);
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      FILL: begin
        fifo_en = fill_en;
        for (int i = 0; i < LANES; i++) begin
          if (fill_en[i]) fifo_d[i*BITS +: BITS] = load_data;
        end
      end
      DRAIN:   fifo_en = skew_mask;
      default: fifo_en = '0;
    endcase
  end

  // Pass sequencing FSM with lane fill counters and drain step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
      for (int i = 0; i < LANES; i++) lane_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          t <= '0;
          for (int i = 0; i < LANES; i++) lane_cnt[i] <= '0;
          if (start) state <= FILL;
        end
        FILL: begin
          // fill_en is never set for a full lane, so counters saturate at DEPTH.
          for (int i = 0; i < LANES; i++) begin
            if (fill_en[i]) lane_cnt[i] <= lane_cnt[i] + 1'b1;
          end
          if (&full_next) begin
            state <= DRAIN;
            t     <= '0;
          end
        end
        DRAIN: begin
          if (t == T_LAST) state <= DONE;
          else             t     <= t + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          t     <= '0;
          for (int i = 0; i < LANES; i++) lane_cnt[i] <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_FEED_PERF_EN
  // Pass length in cycles: the start cycle counts as 1, then every busy cycle adds one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= 32'd1;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
